// File: rtl/k15_pipe_pkg.sv
// k15_pipe_pkg: shared types and elaboration helpers for the k15 elastic pipe.
//   stage_t        : per-stage buffer kind (EB1 single entry, EB15 two-entry skid)
//   stage_kind()   : decodes a skid mask bit into a stage kind
//   stage_entries(): entry count of one stage kind
//   pipe_capacity(): total words a pipe of a given shape can hold
//   occ_width()    : occupancy counter width for a given depth
package k15_pipe_pkg;

  typedef enum logic {
    STAGE_EB1  = 1'b0,
    STAGE_EB15 = 1'b1
  } stage_t;

  // Width of a single stage's entry count (0..2).
  localparam int unsigned CNT_W = 2;

  function automatic stage_t stage_kind(input logic [31:0] mask, input int unsigned idx);
    return mask[5'(idx)] ? STAGE_EB15 : STAGE_EB1;
  endfunction

  function automatic int unsigned stage_entries(input stage_t kind);
    return (kind == STAGE_EB15) ? 2 : 1;
  endfunction

  function automatic int unsigned pipe_capacity(input int unsigned depth, input logic [31:0] mask);
    int unsigned cap;
    cap = 0;
    for (int unsigned k = 0; k < depth; k++) cap += stage_entries(stage_kind(mask, k));
    return cap;
  endfunction

  // Sized for the worst case of every stage being a skid stage.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/k15_elastic_pipe_if.sv
// k15_elastic_pipe_if: one req/ack word channel.
//   dat : DW-bit payload
//   req : word valid (driven by master)
//   ack : word accepted (driven by slave)
// A transfer happens on any cycle with req & ack.
interface k15_elastic_pipe_if #(
  parameter int unsigned DW = 24
);
  logic [DW-1:0] dat;
  logic          req;
  logic          ack;

  modport master (output dat, output req, input ack);
  modport slave  (input dat, input req, output ack);
endinterface

// File: rtl/k15_eb15_stage.sv
// k15_eb15_stage: one EB1.5 elastic stage (2-entry skid buffer).
//   clk, reset       : clock, synchronous active-high reset
//   flush            : synchronous drop of both entries
//   up_dat/req/ack   : upstream side; up_ack is registered (~full)
//   dn_dat/req/ack   : downstream side, 1-cycle latency
//   count            : entries currently held (0..2)
module k15_eb15_stage
  import k15_pipe_pkg::*;
#(
  parameter int unsigned DW = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [DW-1:0]    up_dat,
  input  logic             up_req,
  output logic             up_ack,
  output logic [DW-1:0]    dn_dat,
  output logic             dn_req,
  input  logic             dn_ack,
  output logic [CNT_W-1:0] count
);

  logic [DW-1:0]    d0;
  logic [DW-1:0]    d1;
  logic             wr_sel;
  logic             sel;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ack_q;
  logic             wr;
  logic             rd;
  logic             en0;
  logic             en1;

  // Write/read strobes and next entry count.
  always_comb begin
    wr      = up_req & ack_q;
    rd      = (cnt != '0) & dn_ack;
    en0     = wr & ~wr_sel;
    en1     = wr & wr_sel;
    cnt_nxt = cnt + CNT_W'(wr) - CNT_W'(rd);
  end

  // Control state; ack is precomputed from the next count so it never
  // depends combinationally on dn_ack.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cnt    <= '0;
      wr_sel <= 1'b0;
      sel    <= 1'b0;
      ack_q  <= 1'b1;
    end else begin
      cnt   <= cnt_nxt;
      ack_q <= (cnt_nxt != CNT_W'(2));
      if (wr) wr_sel <= ~wr_sel;
      if (rd) sel    <= ~sel;
    end
  end

  // Payload registers, not reset.
  always_ff @(posedge clk) begin
    if (en0) d0 <= up_dat;
    if (en1) d1 <= up_dat;
  end

  assign up_ack = ack_q;
  assign dn_req = (cnt != '0);
  assign dn_dat = sel ? d1 : d0;
  assign count  = cnt;

endmodule

// File: rtl/k15_elastic_pipe.sv
// k15_elastic_pipe: DEPTH-stage elastic req/ack pipe for DW-bit words.
// Stage 0 sits at the target (upstream) side; SKID_MASK bit k selects an
// EB1.5 skid stage for stage k, otherwise a single-entry EB1 stage.
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : drop all held words; t.ack is 0 that cycle
//   t (slave)             : upstream channel (t_dat/t_req/t_ack)
//   i (master)            : downstream channel (i_dat/i_req/i_ack)
//   occupancy             : words currently held
//   xfer_cnt / stall_cnt  : delivered words / stalled output cycles
// Optional feature macro: K15_PIPE_STATS_EN builds the saturating
// statistics counters; without it both counter ports read 0.
module k15_elastic_pipe
  import k15_pipe_pkg::*;
#(
  parameter int unsigned      DW        = 24,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [DEPTH-1:0] SKID_MASK = 3'b101
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  k15_elastic_pipe_if.slave            t,
  k15_elastic_pipe_if.master           i,
  output logic [occ_width(DEPTH)-1:0]  occupancy,
  output logic [31:0]                  xfer_cnt,
  output logic [31:0]                  stall_cnt
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  // link k feeds stage k; link k+1 is stage k's output.
  logic [DW-1:0]    link_dat [DEPTH+1];
  logic             link_req [DEPTH+1];
  logic             link_ack [DEPTH+1];
  logic [CNT_W-1:0] stage_cnt [DEPTH];

  // Flush blocks intake for the cycle; the output side is left alone.
  assign link_dat[0]     = t.dat;
  assign link_req[0]     = t.req & ~flush;
  assign t.ack           = link_ack[0] & ~flush;
  assign i.dat           = link_dat[DEPTH];
  assign i.req           = link_req[DEPTH];
  assign link_ack[DEPTH] = i.ack;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (stage_kind(32'(SKID_MASK), g) == STAGE_EB15) begin : g_eb15
      k15_eb15_stage #(.DW(DW)) u_stage (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .up_dat (link_dat[g]),
        .up_req (link_req[g]),
        .up_ack (link_ack[g]),
        .dn_dat (link_dat[g+1]),
        .dn_req (link_req[g+1]),
        .dn_ack (link_ack[g+1]),
        .count  (stage_cnt[g])
      );
    end else begin : g_eb1
      logic [DW-1:0] dat_q;
      logic          vld_q;

      // Whenever the stage can accept, its next valid is simply the incoming req.
      always_ff @(posedge clk) begin
        if (reset || flush) vld_q <= 1'b0;
        else if (link_ack[g]) vld_q <= link_req[g];
      end

      always_ff @(posedge clk) begin
        if (link_req[g] && link_ack[g]) dat_q <= link_dat[g];
      end

      // Pass-through ack lets a full EB1 take a word while it hands one on.
      assign link_ack[g]   = ~vld_q | link_ack[g+1];
      assign link_req[g+1] = vld_q;
      assign link_dat[g+1] = dat_q;
      assign stage_cnt[g]  = {1'b0, vld_q};
    end
  end

  // Sum of registered per-stage counts, so it moves the cycle after a transfer.
  always_comb begin
    occupancy = '0;
    for (int unsigned k = 0; k < DEPTH; k++) occupancy = occupancy + OCC_W'(stage_cnt[k]);
  end

`ifdef K15_PIPE_STATS_EN
  logic [31:0] xfer_q;
  logic [31:0] stall_q;

  // Saturating counters; cleared by reset only, flush leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      if (i.req && i.ack && (xfer_q != 32'hFFFF_FFFF)) xfer_q <= xfer_q + 32'd1;
      if (i.req && !i.ack && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign xfer_cnt  = xfer_q;
  assign stall_cnt = stall_q;
`else
  assign xfer_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_k15_elastic_pipe.sv
// tb_k15_elastic_pipe: scoreboard bench for k15_elastic_pipe (DW=24, DEPTH=3,
// SKID_MASK=3'b101, capacity 5). Accepted words are queued by an intake
// process; a separate monitor pops and compares each delivered word and
// tracks the expected occupancy every cycle.
module tb_k15_elastic_pipe;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned OCC_W = 3;

`ifdef K15_PIPE_STATS_EN
  localparam int unsigned EXP_XFER  = 10;
  localparam int unsigned EXP_STALL = 7;
`else
  localparam int unsigned EXP_XFER  = 0;
  localparam int unsigned EXP_STALL = 0;
`endif

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic [OCC_W-1:0] occupancy;
  logic [31:0]      xfer_cnt;
  logic [31:0]      stall_cnt;

  k15_elastic_pipe_if #(.DW(DW)) t_if ();
  k15_elastic_pipe_if #(.DW(DW)) i_if ();

  k15_elastic_pipe #(.DW(DW), .DEPTH(DEPTH), .SKID_MASK(3'b101)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .t         (t_if),
    .i         (i_if),
    .occupancy (occupancy),
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int            n_checks  = 0;
  int            n_errors  = 0;
  int            model_occ = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Intake: every accepted word becomes an expected delivery.
  always @(negedge clk) begin
    if (!reset && t_if.req && t_if.ack) exp_q.push_back(t_if.dat);
  end

  // Monitor: check occupancy against the model, pop and compare deliveries.
  always @(negedge clk) begin
    if (reset) begin
      model_occ = 0;
    end else begin
      chk("occupancy", 32'(occupancy), 32'(model_occ));
      if (i_if.req && i_if.ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: actual=0x%0h required=none at t=%0t", i_if.dat, $time);
        end else begin
          exp_word = exp_q.pop_front();
          chk("deliver_data", 32'(i_if.dat), 32'(exp_word));
        end
      end
      if (flush) model_occ = 0;
      else model_occ = model_occ + int'(t_if.req && t_if.ack) - int'(i_if.req && i_if.ack);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    flush      = 1'b0;
    t_if.req   = 1'b0;
    t_if.dat   = '0;
    i_if.ack   = 1'b0;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Bounded drain with i_ack high; expiry is a failed comparison.
  task automatic drain(input string name, input int budget);
    int n;
    n        = 0;
    t_if.req = 1'b0;
    i_if.ack = 1'b1;
    while ((exp_q.size() != 0 || occupancy != '0) && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(exp_q.size() == 0 && occupancy == '0), 32'd1);
  endtask

  // Offer words for n cycles with i_ack low; returns how many were accepted.
  task automatic fill(input int cycles, output int acc);
    acc      = 0;
    i_if.ack = 1'b0;
    t_if.req = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      t_if.dat = DW'(32'h200 + acc);
      @(negedge clk);
      if (t_if.req && t_if.ack) acc++;
      step();
    end
  endtask

  initial begin
    int acc;
    int sent;
    int cyc;
    int waited;

    t_if.req = 1'b0;
    t_if.dat = '0;
    i_if.ack = 1'b0;
    do_reset();

    // Reset state.
    @(negedge clk);
    chk("rst_i_req", 32'(i_if.req), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_t_ack", 32'(t_if.ack), 32'd1);
    chk("rst_xfer", xfer_cnt, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    step();

    // Single word latency: out exactly 3 cycles after acceptance.
    i_if.ack = 1'b1;
    t_if.req = 1'b1;
    t_if.dat = 24'hABCDEF;
    @(negedge clk);
    chk("lat_accept", 32'(t_if.ack), 32'd1);
    step();
    t_if.req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("lat_i_req", 32'(i_if.req), 32'(c == 3));
      if (c == 3) chk("lat_i_dat", 32'(i_if.dat), 32'hABCDEF);
      step();
    end
    drain("lat_drain", 20);

    // Stream 0..99 at full rate: word c-3 appears in cycle c.
    for (int c = 0; c < 104; c++) begin
      t_if.req = (c < 100);
      t_if.dat = DW'(c);
      @(negedge clk);
      if (c < 100) chk("stream_t_ack", 32'(t_if.ack), 32'd1);
      if (c >= 3 && c < 103) begin
        chk("stream_i_req", 32'(i_if.req), 32'd1);
        chk("stream_i_dat", 32'(i_if.dat), 32'(c - 3));
      end else begin
        chk("stream_i_req_idle", 32'(i_if.req), 32'd0);
      end
      step();
    end
    drain("stream_drain", 20);

    // Fill to capacity with i_ack low, then drain in order.
    fill(8, acc);
    chk("fill_count", 32'(acc), 32'd5);
    @(negedge clk);
    chk("fill_t_ack", 32'(t_if.ack), 32'd0);
    chk("fill_occ", 32'(occupancy), 32'd5);
    step();
    t_if.req = 1'b0;
    i_if.ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("fill_drain_req", 32'(i_if.req), 32'd1);
      chk("fill_drain_dat", 32'(i_if.dat), 32'h200 + 32'(k));
      step();
    end
    drain("fill_drain", 20);

    // Flush at capacity; the word offered in the flush cycle is dropped.
    fill(8, acc);
    @(negedge clk);
    chk("flush_full_occ_pre", 32'(occupancy), 32'd5);
    step();
    flush    = 1'b1;
    t_if.req = 1'b1;
    t_if.dat = 24'h000777;
    @(negedge clk);
    chk("flush_full_t_ack", 32'(t_if.ack), 32'd0);
    step();
    flush    = 1'b0;
    t_if.req = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_full_occ", 32'(occupancy), 32'd0);
    chk("flush_full_i_req", 32'(i_if.req), 32'd0);
    i_if.ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("flush_full_idle", 32'(i_if.req), 32'd0);
    end
    step();

    // Flush with one word in flight, where t_ack would otherwise be 1.
    i_if.ack = 1'b0;
    t_if.req = 1'b1;
    t_if.dat = 24'h000555;
    step();
    t_if.req = 1'b0;
    step();
    flush    = 1'b1;
    t_if.req = 1'b1;
    t_if.dat = 24'h000777;
    @(negedge clk);
    chk("flush_part_t_ack", 32'(t_if.ack), 32'd0);
    step();
    flush    = 1'b0;
    t_if.req = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_part_occ", 32'(occupancy), 32'd0);
    chk("flush_part_i_req", 32'(i_if.req), 32'd0);
    chk("flush_part_t_ack_after", 32'(t_if.ack), 32'd1);
    i_if.ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("flush_part_idle", 32'(i_if.req), 32'd0);
    end
    step();

    // Random handshakes, 10k words.
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      t_if.req = 1'($urandom_range(0, 1));
      t_if.dat = DW'($urandom);
      i_if.ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (t_if.req && t_if.ack) sent++;
      step();
      cyc++;
    end
    chk("rand_sent", 32'(sent), 32'd10000);
    drain("rand_drain", 50);

    // Statistics: 7 stall cycles then 10 deliveries since reset.
    do_reset();
    @(negedge clk);
    chk("stats_rst_xfer", xfer_cnt, 32'd0);
    chk("stats_rst_stall", stall_cnt, 32'd0);
    step();
    i_if.ack = 1'b0;
    t_if.req = 1'b1;
    t_if.dat = 24'h000100;
    step();
    t_if.req = 1'b0;
    waited   = 0;
    @(negedge clk);
    while (!i_if.req && waited < 10) begin
      step();
      waited++;
      @(negedge clk);
    end
    chk("stats_first_req", 32'(i_if.req), 32'd1);
    for (int k = 1; k < 7; k++) begin
      step();
      @(negedge clk);
    end
    step();
    i_if.ack = 1'b1;
    step();
    for (int k = 0; k < 9; k++) begin
      t_if.req = 1'b1;
      t_if.dat = DW'(32'h101 + 32'(k));
      step();
    end
    drain("stats_drain", 20);
    @(negedge clk);
    chk("stats_xfer", xfer_cnt, 32'(EXP_XFER));
    chk("stats_stall", stall_cnt, 32'(EXP_STALL));
    step();

    // Reset mid-stream behaves like a clean reset.
    fill(3, acc);
    do_reset();
    @(negedge clk);
    chk("midrst_occ", 32'(occupancy), 32'd0);
    chk("midrst_i_req", 32'(i_if.req), 32'd0);
    chk("midrst_t_ack", 32'(t_if.ack), 32'd1);
    chk("midrst_xfer", xfer_cnt, 32'd0);
    chk("midrst_stall", stall_cnt, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
